// File: rtl/booth_controller.sv
// Control FSM for a 16-bit radix-2 Booth multiplier datapath.
// Define BOOTH_SKIP_EN to shift during EVAL on 00/11 bit pairs instead of going through SHIFT.
module booth_controller (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic q0,
  input  logic qm1,
  input  logic eqz,
  output logic LdA,
  output logic LdQ,
  output logic LdM,
  output logic clrA,
  output logic clrQ,
  output logic clrff,
  output logic sftA,
  output logic sftQ,
  output logic decr,
  output logic LdCnt,
  output logic addsub,
  output logic busy,
  output logic done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_M,
    LOAD_Q,
    EVAL,
    SHIFT,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The iteration counter lives in the datapath; eqz ends the run before any further add/sub.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD_M;
      LOAD_M:  next_state = LOAD_Q;
      LOAD_Q:  next_state = EVAL;
      EVAL: begin
        if (eqz) begin
          next_state = DONE;
        end else if (q0 != qm1) begin
          next_state = SHIFT;
        end else begin
`ifdef BOOTH_SKIP_EN
          next_state = EVAL;
`else
          next_state = SHIFT;
`endif
        end
      end
      SHIFT:   next_state = EVAL;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    LdA    = 1'b0;
    LdQ    = 1'b0;
    LdM    = 1'b0;
    clrA   = 1'b0;
    clrQ   = 1'b0;
    clrff  = 1'b0;
    sftA   = 1'b0;
    sftQ   = 1'b0;
    decr   = 1'b0;
    LdCnt  = 1'b0;
    addsub = 1'b0;
    done   = 1'b0;
    busy   = (state != IDLE);
    case (state)
      LOAD_M: begin
        LdM   = 1'b1;
        clrA  = 1'b1;
        clrff = 1'b1;
        LdCnt = 1'b1;
      end
      LOAD_Q: LdQ = 1'b1;
      EVAL: begin
        if (!eqz) begin
          case ({q0, qm1})
            2'b10: LdA = 1'b1;
            2'b01: begin
              LdA    = 1'b1;
              addsub = 1'b1;
            end
            default: begin
`ifdef BOOTH_SKIP_EN
              sftA = 1'b1;
              sftQ = 1'b1;
              decr = 1'b1;
`endif
            end
          endcase
        end
      end
      SHIFT: begin
        sftA = 1'b1;
        sftQ = 1'b1;
        decr = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule
